eda_neigh_compare: RTL and testbench
====================================

Name: eda_neigh_compare

Overview:
- Next-generation neighbourhood comparator for the regional-maximum engine.
- Accepts a WIN x WIN pixel window through a valid/ready handshake and computes the maximum over eligible neighbours with a registered max tree.
- Reports whether the centre pixel is a regional-max candidate, plus the mask of plateau neighbours equal to it.
- Streams the not-yet-iterated plateau neighbour indices one at a time to the downstream FIFO through a second valid/ready handshake.

Parameters:
- PIXEL_WIDTH, 8, bits per pixel.
- WIN, 3, window side length; odd, >= 3.
- NEIGH, WIN*WIN-1, number of neighbours (derived).
- IDX_WIDTH, $clog2(NEIGH), width of a neighbour index (derived).
- TREE_DEPTH, $clog2(NEIGH), number of registered max-tree levels (derived).

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort to IDLE.
- conn8  input  1  1 = all neighbours eligible; 0 = only neighbours on the centre row or centre column; sampled on accept.
- in_valid  input  1  window request.
- in_ready  output  1  block can accept a window.
- window_values  input  PIXEL_WIDTH*WIN*WIN  row-major window, position 0 = top-left, centre at C=(WIN*WIN-1)/2.
- neigh_valid  input  NEIGH  neighbour lies inside the image.
- iterated_idx  input  NEIGH  neighbour already visited.
- res_valid  output  1  one-cycle result strobe.
- is_max  output  1  centre >= all eligible neighbours.
- equal_mask  output  NEIGH  eligible neighbours equal to the centre; held until the next accept.
- push_valid  output  1  push_idx is valid.
- push_ready  input  1  FIFO accepts push_idx.
- push_idx  output  IDX_WIDTH  neighbour index to push.
- push_last  output  1  push_idx is the final index for this window.

Behaviour:
- Neighbour mapping: neighbour n corresponds to window position n when n < C, else position n+1.
- eligible[n] = neigh_valid[n] & (conn8 | row(n)==WIN/2 | col(n)==WIN/2).
- Ineligible neighbour values are forced to 0 before the tree. Because the centre is always >= 0, they never affect is_max.
- FSM states: IDLE, COMPUTE, PUSH.
  - IDLE: in_ready=1. The accept cycle is in_valid & in_ready. On accept, register the window, eligible mask, iterated_idx and conn8; load the latency counter; go to COMPUTE.
  - COMPUTE: in_ready=0. The tree advances one level per cycle and a final compare stage follows. res_valid is asserted exactly LAT = TREE_DEPTH+1 cycles after the accept cycle (4 for WIN=3).
  - End of COMPUTE:
    - is_max = centre >= max_neigh.
    - equal_mask = eligible & (neigh==centre) & {NEIGH{is_max}}.
    - push_mask = equal_mask & ~iterated_sampled.
    - If push_mask==0, go to IDLE in the same cycle as res_valid; otherwise go to PUSH.
  - PUSH:
    - push_idx is the lowest set bit of push_mask; push_valid=1.
    - push_last=1 when exactly one bit remains set.
    - On push_valid & push_ready, clear that bit. If it was the last bit, go to IDLE.
    - When push_ready=0, push_idx and push_valid stay stable.
- Each index is pushed exactly once per window; no duplicates even if push_ready toggles.
- Arithmetic: comparisons are unsigned PIXEL_WIDTH-bit. Ties count as is_max=1.
- flush: from any state, go to IDLE next cycle; push_valid=0, res_valid=0, push_mask cleared. equal_mask and is_max are retained. If flush and in_valid are both high in IDLE, flush wins and nothing is accepted.
- Reset values: in_ready=1 (state IDLE), res_valid=0, is_max=0, equal_mask=0, push_valid=0, push_idx=0, push_last=0. The counter and all tree pipeline registers are cleared.
- Reset mid-operation discards the window with no partial output.
- Back-to-back operation: in_ready rises the cycle after the final push handshake, or the cycle after res_valid when there is nothing to push. Minimum issue interval is LAT+1 cycles.

Decomposition:
- Package eda_neigh_pkg: state enum (IDLE, COMPUTE, PUSH) and function neigh_to_pos(n, WIN). Also is_cross(n, WIN) for the conn4 eligibility test.
- Sub-module eda_max_tree: parametrised registered max tree (N inputs, PIXEL_WIDTH, one register per level, pass-through valid). Odd element counts pass through a level delayed.

Test Plan:
- WIN=3, conn8=1, all valid, centre 50, neighbours 10..40 -> res_valid 4 cycles after accept, is_max=1, equal_mask=0, no push_valid, in_ready high next cycle.
- Centre 50; neighbours 1,3,6 = 50, rest 20; iterated_idx=8'h08 (bit 3); push_ready=1 -> equal_mask=8'h4A, pushes idx 1 then 6, push_last on 6.
- Same window with push_ready low 3 cycles then high -> push_idx=1 held stable, no duplicate, total 2 handshakes.
- Neighbour 0 = 255 with neigh_valid[0]=0, others 30, centre 40 -> is_max=1. Same window with conn8=0 and neighbour 0 = 255 valid (corner) -> is_max=1; neighbour 1 = 255 valid -> is_max=0, equal_mask=0.
- flush asserted during PUSH after first handshake -> push_valid=0 next cycle, IDLE, next window processed normally. Async reset in COMPUTE -> all outputs at reset values.
- WIN=5, centre 100, neighbour 23 = 100, others 0 -> res_valid at LAT=6 cycles, single push idx 23 with push_last=1.

Source files
------------

// File: rtl/eda_neigh_compare_pkg.sv
// Shared types and elaboration helpers for the neighbourhood comparator.
// Neighbour indexing skips the centre pixel of the row-major window.
package eda_neigh_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        PUSH    = 2'd2
    } state_e;

    function automatic int neigh_to_pos(input int n, input int win);
        int c;
        c = (win * win - 1) / 2;
        return (n < c) ? n : n + 1;
    endfunction

    // Neighbour sits on the centre row or centre column (4-connected set).
    function automatic bit is_cross(input int n, input int win);
        int pos;
        pos = neigh_to_pos(n, win);
        return ((pos / win) == (win / 2)) || ((pos % win) == (win / 2));
    endfunction

    function automatic int tree_cnt(input int n, input int lvl);
        int c;
        c = n;
        for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
        return c;
    endfunction

endpackage

// File: rtl/eda_neigh_compare_if.sv
// Window request, result and index-push signals of the neighbourhood comparator.
interface eda_neigh_compare_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int WIN         = 3
);
    localparam int NEIGH     = WIN * WIN - 1;
    localparam int IDX_WIDTH = $clog2(NEIGH);

    logic                             flush;
    logic                             conn8;
    logic                             in_valid;
    logic                             in_ready;
    logic [PIXEL_WIDTH*WIN*WIN-1:0]   window_values;
    logic [NEIGH-1:0]                 neigh_valid;
    logic [NEIGH-1:0]                 iterated_idx;
    logic                             res_valid;
    logic                             is_max;
    logic [NEIGH-1:0]                 equal_mask;
    logic                             push_valid;
    logic                             push_ready;
    logic [IDX_WIDTH-1:0]             push_idx;
    logic                             push_last;

    modport master (
        output flush, conn8, in_valid, window_values, neigh_valid, iterated_idx, push_ready,
        input  in_ready, res_valid, is_max, equal_mask, push_valid, push_idx, push_last
    );

    modport slave (
        input  flush, conn8, in_valid, window_values, neigh_valid, iterated_idx, push_ready,
        output in_ready, res_valid, is_max, equal_mask, push_valid, push_idx, push_last
    );

endinterface

// File: rtl/eda_neigh_compare_max_tree.sv
// Registered pairwise max tree, one register level per halving step.
// An odd element at the end of a level is carried forward unchanged.
module eda_max_tree
    import eda_neigh_pkg::*;
#(
    parameter int N           = 8,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     valid_i,
    input  logic [N*PIXEL_WIDTH-1:0] data_i,
    output logic                     valid_o,
    output logic [PIXEL_WIDTH-1:0]   max_o
);
    localparam int DEPTH = $clog2(N);
    localparam int PW    = PIXEL_WIDTH;

    for (genvar l = 0; l <= DEPTH; l++) begin : g_lvl
        localparam int CNT = tree_cnt(N, l);
        logic [CNT*PW-1:0] v;
        logic              vld;

        if (l == 0) begin : g_in
            assign v   = data_i;
            assign vld = valid_i;
        end else begin : g_reg
            localparam int PCNT = tree_cnt(N, l - 1);
            logic [CNT*PW-1:0] d;

            for (genvar i = 0; i < CNT; i++) begin : g_node
                if (2 * i + 1 < PCNT) begin : g_pair
                    assign d[i*PW +: PW] =
                        (g_lvl[l-1].v[2*i*PW +: PW] >= g_lvl[l-1].v[(2*i+1)*PW +: PW])
                        ? g_lvl[l-1].v[2*i*PW +: PW] : g_lvl[l-1].v[(2*i+1)*PW +: PW];
                end else begin : g_pass
                    assign d[i*PW +: PW] = g_lvl[l-1].v[2*i*PW +: PW];
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    v   <= '0;
                    vld <= 1'b0;
                end else begin
                    vld <= g_lvl[l-1].vld;
                    if (g_lvl[l-1].vld) v <= d;
                end
            end
        end
    end

    assign max_o   = g_lvl[DEPTH].v;
    assign valid_o = g_lvl[DEPTH].vld;

endmodule

// File: rtl/eda_neigh_compare.sv
// Regional-maximum neighbourhood comparator: max tree, centre compare and
// streaming of not-yet-iterated plateau neighbour indices.
//   state   | meaning
//   IDLE    | ready for a window
//   COMPUTE | tree running, then result strobe
//   PUSH    | emitting plateau indices, lowest first
module eda_neigh_compare
    import eda_neigh_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int WIN         = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    eda_neigh_compare_if.slave bus
);
    localparam int NEIGH      = WIN * WIN - 1;
    localparam int IDX_WIDTH  = $clog2(NEIGH);
    localparam int TREE_DEPTH = $clog2(NEIGH);
    localparam int C          = (WIN * WIN - 1) / 2;
    localparam int PW         = PIXEL_WIDTH;
    localparam int CNT_W      = $clog2(TREE_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TREE_DEPTH - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 res_valid_q, res_valid_d;
    logic                 is_max_q, is_max_d;
    logic [NEIGH-1:0]     equal_mask_q, equal_mask_d;
    logic [NEIGH-1:0]     push_mask_q, push_mask_d;
    logic [PW-1:0]        centre_q;
    logic [NEIGH*PW-1:0]  neigh_q;
    logic [NEIGH-1:0]     elig_q;
    logic [NEIGH-1:0]     iter_q;

    logic                 accept;
    logic [NEIGH-1:0]     elig_w;
    logic [NEIGH*PW-1:0]  nval_w;
    logic [NEIGH*PW-1:0]  tree_in_w;
    logic [PW-1:0]        centre_w;
    logic                 tree_vld;
    logic [PW-1:0]        tree_max;
    logic [NEIGH-1:0]     eq_w;
    logic                 is_max_w;
    logic [NEIGH-1:0]     low_bit_w;
    logic                 last_w;
    logic [IDX_WIDTH-1:0] push_idx_w;

    assign accept   = (state_q == IDLE) & bus.in_valid & ~bus.flush;
    assign centre_w = bus.window_values[C*PW +: PW];

    // Ineligible neighbours enter the tree as zero so they can never beat the centre.
    for (genvar n = 0; n < NEIGH; n++) begin : g_neigh
        localparam int POS   = neigh_to_pos(n, WIN);
        localparam bit CROSS = is_cross(n, WIN);
        assign elig_w[n]             = bus.neigh_valid[n] & (bus.conn8 | CROSS);
        assign nval_w[n*PW +: PW]    = bus.window_values[POS*PW +: PW];
        assign tree_in_w[n*PW +: PW] = elig_w[n] ? nval_w[n*PW +: PW] : '0;
        assign eq_w[n]               = elig_q[n] & (neigh_q[n*PW +: PW] == centre_q);
    end

    eda_max_tree #(
        .N           (NEIGH),
        .PIXEL_WIDTH (PIXEL_WIDTH)
    ) u_tree (
        .clk     (clk),
        .reset_n (reset_n),
        .valid_i (accept),
        .data_i  (tree_in_w),
        .valid_o (tree_vld),
        .max_o   (tree_max)
    );

    assign is_max_w  = (centre_q >= tree_max);
    assign low_bit_w = push_mask_q & (~push_mask_q + NEIGH'(1));
    assign last_w    = ((push_mask_q & (push_mask_q - NEIGH'(1))) == '0);

    always_comb begin
        push_idx_w = '0;
        for (int i = NEIGH - 1; i >= 0; i--) begin
            if (push_mask_q[i]) push_idx_w = IDX_WIDTH'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        res_valid_d  = 1'b0;
        is_max_d     = is_max_q;
        equal_mask_d = equal_mask_q;
        push_mask_d  = push_mask_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = CNT_LOAD;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (res_valid_q) begin
                    state_d = (push_mask_q != '0) ? PUSH : IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (tree_vld) begin
                    is_max_d     = is_max_w;
                    equal_mask_d = eq_w & {NEIGH{is_max_w}};
                    push_mask_d  = eq_w & {NEIGH{is_max_w}} & ~iter_q;
                    res_valid_d  = 1'b1;
                end
            end
            PUSH: begin
                if (bus.push_ready) begin
                    push_mask_d = push_mask_q & ~low_bit_w;
                    if (last_w) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush) begin
            state_d     = IDLE;
            res_valid_d = 1'b0;
            push_mask_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            res_valid_q  <= 1'b0;
            is_max_q     <= 1'b0;
            equal_mask_q <= '0;
            push_mask_q  <= '0;
            centre_q     <= '0;
            neigh_q      <= '0;
            elig_q       <= '0;
            iter_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            res_valid_q  <= res_valid_d;
            is_max_q     <= is_max_d;
            equal_mask_q <= equal_mask_d;
            push_mask_q  <= push_mask_d;
            if (accept) begin
                centre_q <= centre_w;
                neigh_q  <= nval_w;
                elig_q   <= elig_w;
                iter_q   <= bus.iterated_idx;
            end
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.res_valid  = res_valid_q;
    assign bus.is_max     = is_max_q;
    assign bus.equal_mask = equal_mask_q;
    assign bus.push_valid = (state_q == PUSH);
    assign bus.push_idx   = push_idx_w;
    assign bus.push_last  = (state_q == PUSH) & last_w;

endmodule

// File: tb/tb_eda_neigh_compare.sv
// Directed bench for eda_neigh_compare: a WIN=3 instance for most scenarios
// and a WIN=5 instance for the deeper tree latency.
module tb_eda_neigh_compare;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [7:0] nb [8];
    logic [7:0] ctr;

    eda_neigh_compare_if #(.PIXEL_WIDTH(8), .WIN(3)) bus3 ();
    eda_neigh_compare_if #(.PIXEL_WIDTH(8), .WIN(5)) bus5 ();

    eda_neigh_compare #(.PIXEL_WIDTH(8), .WIN(3)) u_dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus3)
    );

    eda_neigh_compare #(.PIXEL_WIDTH(8), .WIN(5)) u_dut5 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus5)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load3();
        for (int n = 0; n < 8; n++) bus3.window_values[((n < 4) ? n : n + 1) * 8 +: 8] = nb[n];
        bus3.window_values[4*8 +: 8] = ctr;
    endtask

    task automatic issue3(input logic c8, input logic [7:0] nv, input logic [7:0] it, output int lat);
        int k;
        k = 0;
        while (!bus3.in_ready && k < 50) begin tick(); k++; end
        load3();
        bus3.conn8        = c8;
        bus3.neigh_valid  = nv;
        bus3.iterated_idx = it;
        bus3.in_valid     = 1'b1;
        tick();
        bus3.in_valid = 1'b0;
        lat = 1;
        while (!bus3.res_valid && lat < 20) begin tick(); lat++; end
    endtask

    task automatic drain3(input int stall, input int exp_n, input int e0, input int e1);
        int hs, st, cyc;
        hs = 0; st = 0; cyc = 0;
        while (hs < exp_n && cyc < 40) begin
            if (bus3.push_valid) begin
                if (st < stall) begin
                    bus3.push_ready = 1'b0;
                    check("stall_idx", 32'(bus3.push_idx), 32'(e0));
                    st++;
                end else begin
                    bus3.push_ready = 1'b1;
                    check("push_idx", 32'(bus3.push_idx), 32'((hs == 0) ? e0 : e1));
                    check("push_last", 32'(bus3.push_last), 32'(hs == exp_n - 1));
                    hs++;
                end
            end else begin
                bus3.push_ready = 1'b0;
            end
            tick();
            cyc++;
        end
        bus3.push_ready = 1'b0;
        check("push_count", 32'(hs), 32'(exp_n));
        check("in_ready_after_push", 32'(bus3.in_ready), 32'd1);
        check("no_dup_push", 32'(bus3.push_valid), 32'd0);
    endtask

    task automatic set_plateau();
        for (int n = 0; n < 8; n++) nb[n] = 8'd20;
        nb[1] = 8'd50; nb[3] = 8'd50; nb[6] = 8'd50;
        ctr = 8'd50;
    endtask

    task automatic set_ramp();
        for (int n = 0; n < 8; n++) nb[n] = 8'(12 + 4 * n);
        ctr = 8'd50;
    endtask

    initial begin
        int lat, k, seen;
        bus3.flush = 0; bus3.conn8 = 1; bus3.in_valid = 0; bus3.window_values = '0;
        bus3.neigh_valid = '0; bus3.iterated_idx = '0; bus3.push_ready = 0;
        bus5.flush = 0; bus5.conn8 = 1; bus5.in_valid = 0; bus5.window_values = '0;
        bus5.neigh_valid = '0; bus5.iterated_idx = '0; bus5.push_ready = 0;

        tick(); tick(); tick();
        check("rst_in_ready", 32'(bus3.in_ready), 32'd1);
        check("rst_res_valid", 32'(bus3.res_valid), 32'd0);
        check("rst_is_max", 32'(bus3.is_max), 32'd0);
        check("rst_equal_mask", 32'(bus3.equal_mask), 32'd0);
        check("rst_push_valid", 32'(bus3.push_valid), 32'd0);
        check("rst_push_idx", 32'(bus3.push_idx), 32'd0);
        check("rst_push_last", 32'(bus3.push_last), 32'd0);
        reset_n = 1'b1;
        tick();

        // Strict maximum, nothing to push.
        set_ramp();
        issue3(1'b1, 8'hFF, 8'h00, lat);
        check("t1_latency", 32'(lat), 32'd4);
        check("t1_is_max", 32'(bus3.is_max), 32'd1);
        check("t1_equal_mask", 32'(bus3.equal_mask), 32'h00);
        check("t1_in_ready_at_res", 32'(bus3.in_ready), 32'd0);
        tick();
        check("t1_res_strobe_one_cycle", 32'(bus3.res_valid), 32'd0);
        check("t1_in_ready_next", 32'(bus3.in_ready), 32'd1);
        check("t1_no_push", 32'(bus3.push_valid), 32'd0);

        // Plateau with neighbour 3 already iterated.
        set_plateau();
        issue3(1'b1, 8'hFF, 8'h08, lat);
        check("t2_latency", 32'(lat), 32'd4);
        check("t2_is_max", 32'(bus3.is_max), 32'd1);
        check("t2_equal_mask", 32'(bus3.equal_mask), 32'h4A);
        drain3(0, 2, 1, 6);

        // Same plateau with downstream back-pressure.
        issue3(1'b1, 8'hFF, 8'h08, lat);
        check("t3_equal_mask", 32'(bus3.equal_mask), 32'h4A);
        drain3(3, 2, 1, 6);

        // Large value on an out-of-image neighbour is ignored.
        for (int n = 0; n < 8; n++) nb[n] = 8'd30;
        nb[0] = 8'd255; ctr = 8'd40;
        issue3(1'b1, 8'hFE, 8'h00, lat);
        check("t4a_is_max", 32'(bus3.is_max), 32'd1);
        check("t4a_equal_mask", 32'(bus3.equal_mask), 32'h00);
        issue3(1'b0, 8'hFF, 8'h00, lat);
        check("t4b_corner_conn4_is_max", 32'(bus3.is_max), 32'd1);
        check("t4b_equal_mask", 32'(bus3.equal_mask), 32'h00);
        nb[0] = 8'd30; nb[1] = 8'd255;
        issue3(1'b0, 8'hFF, 8'h00, lat);
        check("t4c_cross_conn4_is_max", 32'(bus3.is_max), 32'd0);
        check("t4c_equal_mask", 32'(bus3.equal_mask), 32'h00);

        // Flush after the first push handshake.
        set_plateau();
        issue3(1'b1, 8'hFF, 8'h08, lat);
        k = 0;
        while (!bus3.push_valid && k < 10) begin tick(); k++; end
        check("t5_first_idx", 32'(bus3.push_idx), 32'd1);
        bus3.push_ready = 1'b1;
        tick();
        bus3.push_ready = 1'b0;
        check("t5_second_idx", 32'(bus3.push_idx), 32'd6);
        bus3.flush = 1'b1;
        tick();
        bus3.flush = 1'b0;
        check("t5_flush_push_valid", 32'(bus3.push_valid), 32'd0);
        check("t5_flush_in_ready", 32'(bus3.in_ready), 32'd1);
        check("t5_flush_keeps_is_max", 32'(bus3.is_max), 32'd1);
        check("t5_flush_keeps_mask", 32'(bus3.equal_mask), 32'h4A);
        set_ramp();
        issue3(1'b1, 8'hFF, 8'h00, lat);
        check("t5_after_flush_latency", 32'(lat), 32'd4);
        check("t5_after_flush_mask", 32'(bus3.equal_mask), 32'h00);
        tick();

        // Flush wins over a simultaneous request in IDLE.
        set_plateau();
        load3();
        bus3.in_valid = 1'b1; bus3.flush = 1'b1;
        tick();
        bus3.in_valid = 1'b0; bus3.flush = 1'b0;
        check("t6_flush_blocks_accept", 32'(bus3.in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus3.res_valid) seen++;
            tick();
        end
        check("t6_no_result", 32'(seen), 32'd0);

        // Asynchronous reset while computing.
        set_plateau();
        load3();
        bus3.iterated_idx = 8'h00;
        bus3.in_valid = 1'b1;
        tick();
        bus3.in_valid = 1'b0;
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("t7_rst_in_ready", 32'(bus3.in_ready), 32'd1);
        check("t7_rst_res_valid", 32'(bus3.res_valid), 32'd0);
        check("t7_rst_is_max", 32'(bus3.is_max), 32'd0);
        check("t7_rst_equal_mask", 32'(bus3.equal_mask), 32'd0);
        check("t7_rst_push_valid", 32'(bus3.push_valid), 32'd0);
        #1 reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus3.res_valid || bus3.push_valid) seen++;
        end
        check("t7_no_partial_output", 32'(seen), 32'd0);

        // WIN=5: deeper tree, single plateau neighbour at index 23.
        bus5.window_values = '0;
        bus5.window_values[12*8 +: 8] = 8'd100;
        bus5.window_values[24*8 +: 8] = 8'd100;
        bus5.neigh_valid  = '1;
        bus5.iterated_idx = '0;
        bus5.conn8        = 1'b1;
        bus5.in_valid     = 1'b1;
        tick();
        bus5.in_valid = 1'b0;
        lat = 1;
        while (!bus5.res_valid && lat < 20) begin tick(); lat++; end
        check("t8_latency", 32'(lat), 32'd6);
        check("t8_is_max", 32'(bus5.is_max), 32'd1);
        check("t8_equal_mask", 32'(bus5.equal_mask), 32'h800000);
        bus5.push_ready = 1'b1;
        k = 0;
        while (!bus5.push_valid && k < 10) begin tick(); k++; end
        check("t8_push_idx", 32'(bus5.push_idx), 32'd23);
        check("t8_push_last", 32'(bus5.push_last), 32'd1);
        tick();
        bus5.push_ready = 1'b0;
        check("t8_single_push", 32'(bus5.push_valid), 32'd0);
        check("t8_in_ready", 32'(bus5.in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
